// File: rtl/rv_ex_ctrl.sv
// ---------------------------------------------------------------------------
// rv_ex_ctrl
//
// Registered, handshaked ALU control decoder placed between decode and
// execute. An instruction's opcode/funct3/funct7 is decoded into a 4-bit ALU
// select, a branch-invert flag and M-extension controls, and the result is
// held in a one-entry output slot. Multiply/divide instructions additionally
// start the external MD unit and wait a fixed latency before the slot is
// presented, back-pressuring decode meanwhile.
//
// Parameters
//   MD_EN   1 = decode RV32M ops as MD ops, 0 = treat them as illegal
//   MD_LAT  MD unit latency in cycles (1..255)
//   CNT_W   latency counter width, derived from MD_LAT
//
// Ports
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   flush_i                synchronous flush, wins over everything else
//   in_valid_i/in_ready_o  input handshake (in_ready_o is combinational)
//   opcode_i/funct3_i/funct7_i  instruction fields
//   out_valid_o/out_ready_i     output slot handshake
//   alu_op_sel_o, br_inv_o, md_sel_o, md_op_o, illegal_o  decoded slot
//   md_start_o             one-cycle start pulse to the MD unit
//   md_busy_o              MD sequence in progress
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; ready never depends on the producer's valid.
//
// FSM state is fully observable on the ports: out_valid_o marks FULL,
// md_busy_o marks MD_WAIT, neither marks IDLE.
// ---------------------------------------------------------------------------
module rv_ex_ctrl #(
  parameter int MD_EN  = 1,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       flush_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] alu_op_sel_o,
  output logic       br_inv_o,
  output logic       md_sel_o,
  output logic [2:0] md_op_o,
  output logic       illegal_o,
  output logic       md_start_o,
  output logic       md_busy_o
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_MD_WAIT = 2'd2;

  // Opcodes
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] SEL_ZERO = 4'b0000;
  localparam logic [3:0] SEL_ILL  = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  // Registered state
  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             br_inv_q,  br_inv_d;
  logic             md_sel_q,  md_sel_d;
  logic [2:0]       md_op_q,   md_op_d;
  logic             illegal_q, illegal_d;
  logic             md_start_q, md_start_d;

  // Decoder outputs for the instruction currently offered
  logic [3:0] dec_alu_sel;
  logic       dec_br_inv;
  logic       dec_md_sel;
  logic [2:0] dec_md_op;
  logic       dec_illegal;
  logic       dec_is_md;

  logic       accept;

  // -------------------------------------------------------------------------
  // Combinational decode. Everything starts as "illegal" and each legal
  // encoding clears the flag, so any unlisted opcode falls out as 1111.
  // -------------------------------------------------------------------------
  always_comb begin
    dec_alu_sel = SEL_ILL;
    dec_br_inv  = 1'b0;
    dec_md_sel  = 1'b0;
    dec_md_op   = 3'b000;
    dec_illegal = 1'b1;
    dec_is_md   = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        if (funct7_i == F7_MULDIV) begin
          // RV32M: only legal when the MD unit is present.
          if (MD_EN != 0) begin
            dec_alu_sel = SEL_ZERO;
            dec_md_sel  = 1'b1;
            dec_md_op   = funct3_i;
            dec_illegal = 1'b0;
            dec_is_md   = 1'b1;
          end
        end else begin
          dec_alu_sel = {funct7_i[5], funct3_i};
          dec_illegal = 1'b0;
        end
      end
      OP_ITYPE: begin
        // Only the shift-right immediate uses funct7[5] (srli vs srai);
        // for every other I-type op those bits are immediate data.
        if (funct3_i == 3'b101) begin
          dec_alu_sel = {funct7_i[5], 3'b101};
        end else begin
          dec_alu_sel = {1'b0, funct3_i};
        end
        dec_illegal = 1'b0;
      end
      OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
        dec_alu_sel = SEL_ZERO;
        dec_illegal = 1'b0;
      end
      OP_BRANCH: begin
        // funct3[0] selects the negated form of each compare pair.
        dec_br_inv = funct3_i[0];
        unique case (funct3_i[2:1])
          2'b00: begin
            dec_alu_sel = 4'b1000;
            dec_illegal = 1'b0;
          end
          2'b10: begin
            dec_alu_sel = 4'b0010;
            dec_illegal = 1'b0;
          end
          2'b11: begin
            dec_alu_sel = 4'b0011;
            dec_illegal = 1'b0;
          end
          default: begin
            dec_alu_sel = SEL_ILL;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_alu_sel = SEL_ILL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake. A FULL slot may be replaced in the same cycle it drains,
  // giving one instruction per cycle. Nothing is accepted while the MD unit
  // is running or while a flush is in progress.
  // -------------------------------------------------------------------------
  assign in_ready_o = !flush_i &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_FULL) && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_sel_d  = alu_sel_q;
    br_inv_d   = br_inv_q;
    md_sel_d   = md_sel_q;
    md_op_d    = md_op_q;
    illegal_d  = illegal_q;
    md_start_d = 1'b0;

    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_FULL: begin
          if (accept) begin
            alu_sel_d = dec_alu_sel;
            br_inv_d  = dec_br_inv;
            md_sel_d  = dec_md_sel;
            md_op_d   = dec_md_op;
            illegal_d = dec_illegal;
            if (dec_is_md) begin
              // The counter holds the number of further cycles to wait
              // after the first MD_WAIT cycle.
              state_d    = ST_MD_WAIT;
              cnt_d      = CNT_LOAD;
              md_start_d = 1'b1;
            end else begin
              state_d = ST_FULL;
            end
          end else if ((state_q == ST_FULL) && out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_MD_WAIT: begin
          if (cnt_q == '0) begin
            state_d = ST_FULL;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_sel_q  <= SEL_ILL;
      br_inv_q   <= 1'b0;
      md_sel_q   <= 1'b0;
      md_op_q    <= 3'b000;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_sel_q  <= alu_sel_d;
      br_inv_q   <= br_inv_d;
      md_sel_q   <= md_sel_d;
      md_op_q    <= md_op_d;
      illegal_q  <= illegal_d;
      md_start_q <= md_start_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid_o  = (state_q == ST_FULL);
  assign md_busy_o    = (state_q == ST_MD_WAIT);
  assign alu_op_sel_o = alu_sel_q;
  assign br_inv_o     = br_inv_q;
  assign md_sel_o     = md_sel_q;
  assign md_op_o      = md_op_q;
  assign illegal_o    = illegal_q;
  assign md_start_o   = md_start_q;

endmodule

// File: tb/tb_rv_ex_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_ex_ctrl
//
// Three instances share one stimulus stream:
//   0: MD_EN=1, MD_LAT=4
//   1: MD_EN=0, MD_LAT=4
//   2: MD_EN=1, MD_LAT=1
// A transaction-level model tracks, per instance, whether the slot holds a
// result, how many MD cycles remain, and the decoded fields of the last
// accepted instruction. A compare process checks every instance against it
// on each falling edge. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_rv_ex_ctrl;

  localparam int N_DUT = 3;

  typedef struct packed {
    logic [3:0] sel;
    logic       inv;
    logic       md_sel;
    logic [2:0] md_op;
    logic       ill;
    logic       is_md;
  } dec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       flush     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [6:0] opcode    = 7'd0;
  logic [2:0] funct3    = 3'd0;
  logic [6:0] funct7    = 7'd0;

  logic [N_DUT-1:0] in_ready, out_valid, br_inv, md_sel, illegal, md_start, md_busy;
  logic [3:0]       alu_sel [N_DUT];
  logic [2:0]       md_op   [N_DUT];

  rv_ex_ctrl #(.MD_EN(1), .MD_LAT(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .alu_op_sel_o(alu_sel[0]), .br_inv_o(br_inv[0]), .md_sel_o(md_sel[0]),
    .md_op_o(md_op[0]), .illegal_o(illegal[0]),
    .md_start_o(md_start[0]), .md_busy_o(md_busy[0])
  );

  rv_ex_ctrl #(.MD_EN(0), .MD_LAT(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .alu_op_sel_o(alu_sel[1]), .br_inv_o(br_inv[1]), .md_sel_o(md_sel[1]),
    .md_op_o(md_op[1]), .illegal_o(illegal[1]),
    .md_start_o(md_start[1]), .md_busy_o(md_busy[1])
  );

  rv_ex_ctrl #(.MD_EN(1), .MD_LAT(1)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
    .alu_op_sel_o(alu_sel[2]), .br_inv_o(br_inv[2]), .md_sel_o(md_sel[2]),
    .md_op_o(md_op[2]), .illegal_o(illegal[2]),
    .md_start_o(md_start[2]), .md_busy_o(md_busy[2])
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t actual=%0h expected=%0h", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit inst_md_en(input int i);
    return (i != 1);
  endfunction

  function automatic int inst_lat(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  // Straight transcription of the instruction table.
  function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input bit en);
    dec_t d;
    d = '{sel: 4'b1111, inv: 1'b0, md_sel: 1'b0, md_op: 3'b000, ill: 1'b1, is_md: 1'b0};
    if (op == 7'b0110011 && f7 == 7'b0000001) begin
      if (en) begin
        d.sel = 4'b0000; d.md_sel = 1'b1; d.md_op = f3; d.ill = 1'b0; d.is_md = 1'b1;
      end
    end else if (op == 7'b0110011) begin
      d.sel = {f7[5], f3}; d.ill = 1'b0;
    end else if (op == 7'b0010011) begin
      d.sel = (f3 == 3'd5) ? {f7[5], 3'b101} : {1'b0, f3}; d.ill = 1'b0;
    end else if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110111 ||
                 op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111) begin
      d.sel = 4'b0000; d.ill = 1'b0;
    end else if (op == 7'b1100011) begin
      d.inv = f3[0];
      case (f3)
        3'd0, 3'd1: begin d.sel = 4'b1000; d.ill = 1'b0; end
        3'd4, 3'd5: begin d.sel = 4'b0010; d.ill = 1'b0; end
        3'd6, 3'd7: begin d.sel = 4'b0011; d.ill = 1'b0; end
        default:    begin d.sel = 4'b1111; d.ill = 1'b1; end
      endcase
    end
    return d;
  endfunction

  bit   m_valid [N_DUT] = '{0, 0, 0};
  int   m_wait  [N_DUT] = '{0, 0, 0};   // MD cycles still to go
  bit   m_start [N_DUT] = '{0, 0, 0};
  dec_t m_f     [N_DUT];

  function automatic bit exp_ready(input int i);
    return !flush && (m_wait[i] == 0) && (!m_valid[i] || out_ready);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < N_DUT; i++) begin
        bit   acc;
        dec_t d;
        if (!rst_n) begin
          m_valid[i] = 0; m_wait[i] = 0; m_start[i] = 0;
        end else if (flush) begin
          m_valid[i] = 0; m_wait[i] = 0; m_start[i] = 0;
        end else begin
          acc = in_valid && exp_ready(i);
          m_start[i] = 0;
          if (m_wait[i] > 0) begin
            m_wait[i]--;
            if (m_wait[i] == 0) m_valid[i] = 1;
          end else begin
            if (m_valid[i] && out_ready) m_valid[i] = 0;
            if (acc) begin
              d = ref_decode(opcode, funct3, funct7, inst_md_en(i));
              m_f[i] = d;
              if (d.is_md) begin
                m_wait[i] = inst_lat(i); m_start[i] = 1; m_valid[i] = 0;
              end else begin
                m_valid[i] = 1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
        chk("out_valid", i, 32'(out_valid[i]), 32'(m_valid[i]));
        chk("in_ready",  i, 32'(in_ready[i]),  32'(exp_ready(i)));
        chk("md_busy",   i, 32'(md_busy[i]),   32'(m_wait[i] > 0));
        chk("md_start",  i, 32'(md_start[i]),  32'(m_start[i]));
        if (m_valid[i]) begin
          chk("alu_sel", i, 32'(alu_sel[i]), 32'(m_f[i].sel));
          chk("br_inv",  i, 32'(br_inv[i]),  32'(m_f[i].inv));
          chk("md_sel",  i, 32'(md_sel[i]),  32'(m_f[i].md_sel));
          chk("md_op",   i, 32'(md_op[i]),   32'(m_f[i].md_op));
          chk("illegal", i, 32'(illegal[i]), 32'(m_f[i].ill));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All directed tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (6) step();
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic chk_reset_vals(input string tag, input int i);
    chk({tag, "_out_valid"}, i, 32'(out_valid[i]), 32'd0);
    chk({tag, "_alu_sel"},   i, 32'(alu_sel[i]),   32'hF);
    chk({tag, "_br_inv"},    i, 32'(br_inv[i]),    32'd0);
    chk({tag, "_md_sel"},    i, 32'(md_sel[i]),    32'd0);
    chk({tag, "_md_op"},     i, 32'(md_op[i]),     32'd0);
    chk({tag, "_illegal"},   i, 32'(illegal[i]),   32'd0);
    chk({tag, "_md_start"},  i, 32'(md_start[i]),  32'd0);
    chk({tag, "_md_busy"},   i, 32'(md_busy[i]),   32'd0);
    chk({tag, "_in_ready"},  i, 32'(in_ready[i]),  32'd1);
  endtask

  // One instruction through instance 0, then literal checks of the slot.
  task automatic send_check(input string nm, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [3:0] e_sel,
                            input logic e_inv, input logic e_ill);
    set_instr(op, f3, f7);
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    @(negedge clk);
    chk({nm, "_valid"},   0, 32'(out_valid[0]), 32'd1);
    chk({nm, "_sel"},     0, 32'(alu_sel[0]),   32'(e_sel));
    chk({nm, "_inv"},     0, 32'(br_inv[0]),    32'(e_inv));
    chk({nm, "_illegal"}, 0, 32'(illegal[0]),   32'(e_ill));
    step();
  endtask

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 11);
    funct3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       funct7 = 7'h00;
      1:       funct7 = 7'h20;
      2:       funct7 = 7'h01;
      default: funct7 = 7'($urandom_range(0, 127));
    endcase
    case (k)
      0, 1, 2: opcode = 7'b0110011;
      3, 4:    opcode = 7'b0010011;
      5:       opcode = 7'b0000011;
      6:       opcode = 7'b0100011;
      7:       opcode = 7'b0110111;
      8:       opcode = 7'b0010111;
      9:       opcode = ($urandom_range(0, 1) == 0) ? 7'b1101111 : 7'b1100111;
      10:      opcode = 7'b1100011;
      default: opcode = 7'($urandom_range(0, 127));
    endcase
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [3:0] exp_q [$];
  int run_len, start_cnt0, busy_cnt0, first0, start_cnt2, busy_cnt2, first2, ready_bad;

  initial begin
    // Reset: outputs at reset values while rst_n is low.
    rst_n = 0;
    repeat (3) step();
    for (int i = 0; i < N_DUT; i++) chk_reset_vals("rst", i);
    rst_n = 1;
    settle();

    // Single-instruction decode, literal expectations.
    send_check("add",   7'b0110011, 3'b000, 7'b0000000, 4'b0000, 1'b0, 1'b0);
    send_check("sub",   7'b0110011, 3'b000, 7'b0100000, 4'b1000, 1'b0, 1'b0);
    send_check("srai",  7'b0010011, 3'b101, 7'b0100000, 4'b1101, 1'b0, 1'b0);
    send_check("andi",  7'b0010011, 3'b111, 7'b0000000, 4'b0111, 1'b0, 1'b0);
    send_check("bne",   7'b1100011, 3'b001, 7'b0000000, 4'b1000, 1'b1, 1'b0);
    send_check("bgeu",  7'b1100011, 3'b111, 7'b0000000, 4'b0011, 1'b1, 1'b0);
    send_check("br010", 7'b1100011, 3'b010, 7'b0000000, 4'b1111, 1'b0, 1'b1);
    send_check("badop", 7'b1111111, 3'b000, 7'b0000000, 4'b1111, 1'b0, 1'b1);
    settle();

    // Eight back-to-back R-type ops: eight consecutive valid cycles, in order.
    run_len = 0;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        set_instr(7'b0110011, 3'(j), 7'b0000000);
        exp_q.push_back({1'b0, 3'(j)});
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      @(negedge clk);
      if (out_valid[0]) begin
        run_len++;
        if (exp_q.size() == 0) chk("stream_extra", 0, 32'(alu_sel[0]), 32'hDEAD);
        else chk("stream_sel", 0, 32'(alu_sel[0]), 32'(exp_q.pop_front()));
      end
      step();
    end
    chk("stream_run", 0, 32'(run_len), 32'd8);
    chk("stream_left", 0, 32'(exp_q.size()), 32'd0);

    // Stall for three cycles: slot frozen, nothing accepted, then resume.
    set_instr(7'b0010011, 3'b111, 7'b0000000);   // andi -> 0111
    in_valid = 1; out_ready = 0;
    step();
    set_instr(7'b0010011, 3'b100, 7'b0000000);   // xori -> 0100
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_ready", 0, 32'(in_ready[0]), 32'd0);
      chk("stall_valid", 0, 32'(out_valid[0]), 32'd1);
      chk("stall_sel",   0, 32'(alu_sel[0]),   32'h7);
      step();
    end
    out_ready = 1;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("resume_valid", 0, 32'(out_valid[0]), 32'd1);
    chk("resume_sel",   0, 32'(alu_sel[0]),   32'h4);
    step();
    @(negedge clk);
    chk("resume_drain", 0, 32'(out_valid[0]), 32'd0);
    step();
    settle();

    // div: latency 4 on instance 0, latency 1 on instance 2, illegal on 1.
    set_instr(7'b0110011, 3'b100, 7'b0000001);
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    start_cnt0 = 0; busy_cnt0 = 0; first0 = -1;
    start_cnt2 = 0; busy_cnt2 = 0; first2 = -1; ready_bad = 0;
    for (int idx = 0; idx < 8; idx++) begin
      @(negedge clk);
      if (idx == 0) begin
        chk("div_noen_valid", 1, 32'(out_valid[1]), 32'd1);
        chk("div_noen_sel",   1, 32'(alu_sel[1]),   32'hF);
        chk("div_noen_ill",   1, 32'(illegal[1]),   32'd1);
      end
      start_cnt0 += int'(md_start[0]);
      busy_cnt0  += int'(md_busy[0]);
      start_cnt2 += int'(md_start[2]);
      busy_cnt2  += int'(md_busy[2]);
      if (md_busy[0] && in_ready[0]) ready_bad++;
      if (out_valid[0] && first0 < 0) begin
        first0 = idx;
        chk("div_md_sel", 0, 32'(md_sel[0]),  32'd1);
        chk("div_md_op",  0, 32'(md_op[0]),   32'h4);
        chk("div_sel",    0, 32'(alu_sel[0]), 32'h0);
      end
      if (out_valid[2] && first2 < 0) first2 = idx;
      step();
    end
    chk("div_start_cnt",  0, 32'(start_cnt0), 32'd1);
    chk("div_busy_cnt",   0, 32'(busy_cnt0),  32'd4);
    chk("div_first_vld",  0, 32'(first0),     32'd4);
    chk("div_ready_busy", 0, 32'(ready_bad),  32'd0);
    chk("div_start_cnt",  2, 32'(start_cnt2), 32'd1);
    chk("div_busy_cnt",   2, 32'(busy_cnt2),  32'd1);
    chk("div_first_vld",  2, 32'(first2),     32'd1);
    settle();

    // mul, then flush during MD_WAIT with an instruction offered.
    set_instr(7'b0110011, 3'b000, 7'b0000001);
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("mul_noen_valid", 1, 32'(out_valid[1]), 32'd1);
    chk("mul_noen_sel",   1, 32'(alu_sel[1]),   32'hF);
    chk("mul_noen_ill",   1, 32'(illegal[1]),   32'd1);
    chk("mul_noen_start", 1, 32'(md_start[1]),  32'd0);
    chk("mul_busy",       0, 32'(md_busy[0]),   32'd1);
    step();
    flush = 1; in_valid = 1;
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    @(negedge clk);
    chk("flush_ready", 0, 32'(in_ready[0]), 32'd0);
    chk("flush_ready", 1, 32'(in_ready[1]), 32'd0);
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("post_flush_busy",  0, 32'(md_busy[0]),   32'd0);
    chk("post_flush_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("post_flush_ready", 0, 32'(in_ready[0]),  32'd1);
    chk("post_flush_valid", 1, 32'(out_valid[1]), 32'd0);
    for (int j = 0; j < 6; j++) begin
      step();
      @(negedge clk);
      chk("flush_stays_empty", 0, 32'(out_valid[0]), 32'd0);
    end
    step();
    settle();

    // Reset asserted in the middle of MD_WAIT.
    set_instr(7'b0110011, 3'b001, 7'b0000001);
    in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    step();
    #2 rst_n = 0;
    #1;
    chk_reset_vals("mid_md_rst", 0);
    @(negedge clk);
    #1 rst_n = 1;
    step();
    settle();

    // Randomized traffic, checked by the compare process each cycle.
    for (int c = 0; c < 3000; c++) begin
      rand_instr();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
